// File: rtl/arb_pkg.sv
// Shared types for the round-robin arbiter: output-register FSM states and index sizing.
package arb_pkg;

  typedef enum logic {
    ARB_EMPTY = 1'b0,
    ARB_FULL  = 1'b1
  } arb_state_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/muxN.sv
// N:1 word multiplexer built as a binary tree of 2:1 muxes; input i sits at d[i*W +: W].
module muxN #(
  parameter int N = 4,
  parameter int W = 32
) (
  input  logic [$clog2(N)-1:0] s,
  input  logic [N*W-1:0]       d,
  output logic [W-1:0]         y
);

  localparam int L = $clog2(N);

  // Heap layout: node 1 is the root, leaves occupy N..2N-1 in input order.
  logic [W-1:0] node [1:2*N-1];

  for (genvar i = 0; i < N; i++) begin : g_leaf
    assign node[N+i] = d[i*W +: W];
  end

  for (genvar lv = 0; lv < L; lv++) begin : g_lvl
    for (genvar m = 0; m < (1 << lv); m++) begin : g_node
      localparam int K = (1 << lv) + m;
      assign node[K] = s[L-1-lv] ? node[2*K+1] : node[2*K];
    end
  end

  assign y = node[1];

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: N valid/ready requesters share one registered W-bit output channel.
module rr_arbiter
  import arb_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N-1:0]             req_valid,
  input  logic [N*W-1:0]           req_data,
  output logic [N-1:0]             req_ready,
  output logic                     out_valid,
  output logic [W-1:0]             out_data,
  output logic [$clog2(N)-1:0]     out_id,
  input  logic                     out_ready
);

  localparam int IW = idx_w(N);

  arb_state_e      state;
  logic [IW-1:0]   last;
  logic [IW-1:0]   start;
  logic [2*N-1:0]  dbl;
  logic [N-1:0]    rot;
  logic [IW-1:0]   off;
  logic [IW-1:0]   g;
  logic            any;
  logic            can_load;
  logic            accept;
  logic [W-1:0]    mux_y;

  assign can_load = (state == ARB_EMPTY) || out_ready;
  assign any      = |req_valid;
  assign accept   = rst && can_load && any;

  // Rotate so the search origin last+1 lands on bit 0; N is a power of two so index math wraps.
  assign start = last + 1'b1;
  assign dbl   = {req_valid, req_valid} >> start;
  assign rot   = dbl[N-1:0];

  always_comb begin
    off = '0;
    for (int j = N - 1; j >= 0; j--) begin
      if (rot[j]) off = IW'(j);
    end
  end

  assign g = start + off;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[g] = 1'b1;
  end

  muxN #(.N(N), .W(W)) u_mux (
    .s (g),
    .d (req_data),
    .y (mux_y)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= ARB_EMPTY;
      last     <= IW'(N - 1);
      out_data <= '0;
      out_id   <= '0;
    end else if (can_load) begin
      if (any) begin
        state    <= ARB_FULL;
        out_data <= mux_y;
        out_id   <= g;
        last     <= g;
      end else begin
        state <= ARB_EMPTY;
      end
    end
  end

  assign out_valid = (state == ARB_FULL);

endmodule

// File: tb/tb_rr_arbiter.sv
// Directed bench for rr_arbiter (N=4, W=32) with hand-computed grant sequences.
module tb_rr_arbiter;

  localparam int N = 4;
  localparam int W = 32;

  logic           clk;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [1:0]     out_id;
  logic           out_ready;

  int nerr = 0;
  int nchk = 0;

  rr_arbiter #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_id    (out_id),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational req_ready settle after an input change.
  task automatic settle();
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [1:0] id, input logic [31:0] d);
    chk({tag, ".valid"}, 64'(out_valid), 64'(v));
    chk({tag, ".id"},    64'(out_id),    64'(id));
    chk({tag, ".data"},  64'(out_data),  64'(d));
  endtask

  localparam logic [N*W-1:0] BASE = {32'hDDDD0003, 32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000};

  logic [1:0]  exp_id [5];
  logic [31:0] bdat [4];

  initial begin
    bdat[0] = 32'hAAAA0000; bdat[1] = 32'hBBBB0001;
    bdat[2] = 32'hCCCC0002; bdat[3] = 32'hDDDD0003;

    rst = 1'b0; req_valid = 4'hF; req_data = BASE; out_ready = 1'b1;
    settle();
    chk("rst.ready0", 64'(req_ready), 64'h0);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("rst.ready", 64'(req_ready), 64'h0);
      chk_out("rst", 1'b0, 2'd0, 32'h0);
    end

    // Rotation with all four requesters valid.
    rst = 1'b1;
    settle();
    chk("rot.first_ready", 64'(req_ready), 64'h1);
    exp_id[0] = 2'd0; exp_id[1] = 2'd1; exp_id[2] = 2'd2; exp_id[3] = 2'd3; exp_id[4] = 2'd0;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk_out("rot", 1'b1, exp_id[c], bdat[exp_id[c]]);
    end

    // Sparse: only 1 and 3, then 2 joins after a grant to 1. last=0 here.
    req_valid = 4'b1010;
    settle();
    chk("sparse.ready", 64'(req_ready), 64'b0010);
    tick(); chk_out("sparse1", 1'b1, 2'd1, bdat[1]);
    tick(); chk_out("sparse3", 1'b1, 2'd3, bdat[3]);
    tick(); chk_out("sparse1b", 1'b1, 2'd1, bdat[1]);
    req_valid = 4'b1110;
    settle();
    chk("join.ready", 64'(req_ready), 64'b0100);
    tick(); chk_out("join2", 1'b1, 2'd2, bdat[2]);
    tick(); chk_out("join3", 1'b1, 2'd3, bdat[3]);

    // Single requester is re-granted every cycle.
    req_valid = 4'b0100;
    req_data  = BASE;
    req_data[2*W +: W] = 32'h12345678;
    for (int c = 0; c < 3; c++) begin
      tick(); chk_out("single2", 1'b1, 2'd2, 32'h12345678);
    end

    // Backpressure holding id 2.
    out_ready = 1'b0;
    req_valid = 4'hF;
    for (int c = 0; c < 5; c++) begin
      settle();
      chk("bp.ready", 64'(req_ready), 64'h0);
      tick();
      chk_out("bp.hold", 1'b1, 2'd2, 32'h12345678);
    end
    out_ready = 1'b1;
    req_data  = BASE;
    settle();
    chk("bp.release_ready", 64'(req_ready), 64'b1000);
    tick(); chk_out("bp.reload", 1'b1, 2'd3, bdat[3]);

    // Drain to empty, then wrap from last+1=2 back to 0.
    req_valid = 4'b0010;
    tick(); chk_out("drain.load1", 1'b1, 2'd1, bdat[1]);
    req_valid = 4'b0000;
    settle();
    chk("drain.ready", 64'(req_ready), 64'h0);
    tick(); chk_out("drain.empty", 1'b0, 2'd1, bdat[1]);
    out_ready = 1'b0;
    req_valid = 4'b0001;
    settle();
    chk("empty.ignores_oready", 64'(req_ready), 64'b0001);
    tick(); chk_out("wrap0", 1'b1, 2'd0, bdat[0]);

    // Reset while FULL; last returns to N-1 so id 0 wins first even though last was 0.
    out_ready = 1'b1;
    req_valid = 4'hF;
    rst = 1'b0;
    settle();
    chk("mrst.ready", 64'(req_ready), 64'h0);
    tick(); chk_out("mrst", 1'b0, 2'd0, 32'h0);
    rst = 1'b1;
    settle();
    chk("mrst.first_ready", 64'(req_ready), 64'b0001);
    tick(); chk_out("mrst.first", 1'b1, 2'd0, bdat[0]);
    tick(); chk_out("mrst.second", 1'b1, 2'd1, bdat[1]);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/rr_arbiter.md
# rr_arbiter

Round-robin arbiter sharing one W-bit output channel among N requesters, each with a valid/ready handshake. Each cycle it picks the next requester in rotation and routes that requester's word through an `muxN` tree, using the grant index as the select. It then captures the word into a single output register. Sits between producer blocks and a shared single-port consumer (bus, FIFO or register-file write port).

## Interface
- `N`, 4: number of requesters. Must be a power of two and ≥ 2 (the `muxN` constraint).
- `W`, 32: data width per requester.
- `clk`  in  1: system clock. All state updates on the rising edge.
- `rst`  in  1: synchronous reset, active-low (`rst`=0 resets on the next `clk` edge).
- `req_valid`  in  N: bit i is asserted when requester i has a word.
- `req_data`  in  N*W: packed request data. Requester i is `req_data[i*W +: W]`, the same packing `muxN` uses, so select i yields requester i.
- `req_ready`  out  N: one-hot or zero. Bit i high means requester i's word is accepted this cycle.
- `out_valid`  out  1: output register holds a word.
- `out_data`  out  W: registered word.
- `out_id`  out  $clog2(N): index of the requester that produced `out_data`.
- `out_ready`  in  1: downstream accepts `out_data` this cycle.

## Operation
- FSM states (in `arb_pkg`):
  - EMPTY: output register empty.
  - FULL: output register holds a word.
- `can_load` = (state==EMPTY) || (state==FULL && `out_ready`).
- Grant search (combinational):
  - Search starts at `last+1` mod N and wraps through all N indices.
  - It selects the first i with `req_valid[i]`=1.
  - `any` = OR of `req_valid`.
- `req_ready[g]` = `can_load && any`. All other bits of `req_ready` are 0.
- On an accept (`can_load && any`) at the clock edge:
  - `out_data` ← `muxN(s=g, d=req_data)`.
  - `out_id` ← g.
  - `last` ← g.
  - Next state is FULL.
- If `can_load && !any`:
  - A FULL register drains (only when `out_ready` is high).
  - Next state is EMPTY.
  - `out_data`, `out_id` and `last` hold their values.
- If state==FULL and `out_ready`=0: everything holds and `req_ready` is all 0 (backpressure).
- Requesters hold `req_valid` and `req_data` stable until they see `req_ready`. The arbiter does not check this.
- Fairness: a requester that keeps `req_valid` asserted is granted within N accepts.
- `out_valid` = (state==FULL).

## Timing
- Reset values:
  - state EMPTY, `out_valid`=0, `out_data`=0, `out_id`=0.
  - `last`=N-1, so requester 0 has first priority.
  - `req_ready`=0 while `rst`=0.
- Latency: a word accepted on edge k is visible on `out_data` after edge k.
- Throughput: one word per cycle while `out_ready`=1 and any request is pending. There are no bubbles between back-to-back grants.
- Simultaneous drain and load: when FULL with `out_ready`=1 and a request pending, the old word leaves and the new word loads on the same edge. State stays FULL.
- Wrap-around: when `last`=N-1, the search starts at 0.
- Single requester: it is re-granted every cycle.
- Reset mid-operation: a held word is discarded and no handshake completes on that edge. A requester whose `req_ready` was suppressed by reset keeps its word.
- `out_ready` is sampled only when FULL. In EMPTY it is ignored.
- `req_ready` depends combinationally on `req_valid` and `out_ready`. There is no combinational path from `req_data`.

## Structure
- `arb_pkg`: FSM state enum (`ARB_EMPTY`, `ARB_FULL`) and a function for the grant-index width.
- Sub-module: `muxN #(.N(N), .W(W))` for the data path, select = grant index.
- The round-robin search stays in this module: one rotate, a priority encode, then rotate back.
- Target is roughly 150–250 lines of RTL.

## Test plan
- Reset:
  - Stimulus: hold `rst`=0 for 3 cycles with all `req_valid`=1.
  - Required: `out_valid`=0, `req_ready`=0 throughout.
  - Stimulus: release reset.
  - Required: first grant is id 0.
- Rotation:
  - Stimulus: N=4, all four valid continuously, `out_ready`=1, `req_data` = {0xDDDD0003, 0xCCCC0002, 0xBBBB0001, 0xAAAA0000}.
  - Required: `out_id` sequence 0,1,2,3,0. `out_data` matches `0x....000i`.
- Sparse requests:
  - Stimulus: only requesters 1 and 3 valid.
  - Required: grants alternate 1,3,1,3 with no bubbles.
  - Stimulus: requester 2 asserts mid-stream after a grant to 1.
  - Required: it is granted next.
- Backpressure:
  - Stimulus: grant id 2 (data 0x12345678), then `out_ready`=0 for 5 cycles.
  - Required: `out_data` and `out_id` hold, `req_ready`=0.
  - Stimulus: `out_ready`=1.
  - Required: drain and reload happen on the same edge.
- Drain to empty:
  - Stimulus: single word from id 1, then `req_valid`=0, `out_ready`=1.
  - Required: `out_valid` drops after one cycle.
  - Stimulus: next request from id 0.
  - Required: id 0 is granted (search starts from `last+1`=2 and wraps).
- Reset mid-stream:
  - Stimulus: assert `rst`=0 while FULL.
  - Required: `out_valid`=0 next cycle and `last`=N-1.
  - Stimulus: release reset with all valid.
  - Required: first grant is id 0.
